// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// State encoding, default geometry and port index constants.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    ISSUE,
    DATA
  } state_t;

  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_DATA_W    = 4;
  localparam int DEF_CLR_VALUE = 0;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_rr.sv
// rr_arb2: combinational two-way round-robin picker.
// elig[1:0], ptr (favoured port) -> gnt_valid, gnt_idx.
module rr_arb2
  import ram_port_arbiter_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |elig;
    gnt_idx   = P0;
    unique case (elig)
      2'b01:   gnt_idx = P0;
      2'b10:   gnt_idx = P1;
      2'b11:   gnt_idx = ptr;
      default: gnt_idx = P0;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Owns a single-port RAM: clears it after reset, then serves two
// req/ack clients round-robin. Ports: CLOCK_50, RESET, req/we/addr/
// wdata/ack/rdata x2, ram_address/ram_data/ram_wren/ram_q, busy, grant.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CLR_VALUE = DEF_CLR_VALUE
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              grant
);

  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [DATA_W-1:0] CLR  = DATA_W'(CLR_VALUE);

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              op_we_q, op_we_d;
  logic              grant_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic              wren_d;
  logic              ack0_d, ack1_d;
  logic [DATA_W-1:0] rdata0_d, rdata1_d;
  logic              busy_d;

  logic [1:0] elig;
  logic       gnt_valid;
  logic       gnt_idx;

  // A client still seeing its ack is not yet a new request.
  assign elig = {req1 & ~ack1, req0 & ~ack0};

  rr_arb2 u_arb (
    .elig      (elig),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q     <= INIT;
      ptr_q       <= P0;
      op_we_q     <= 1'b0;
      grant       <= P0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      busy        <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_we_q     <= op_we_d;
      grant       <= grant_d;
      ram_address <= addr_d;
      ram_data    <= data_d;
      ram_wren    <= wren_d;
      ack0        <= ack0_d;
      ack1        <= ack1_d;
      rdata0      <= rdata0_d;
      rdata1      <= rdata1_d;
      busy        <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    op_we_d  = op_we_q;
    grant_d  = grant;
    addr_d   = ram_address;
    data_d   = ram_data;
    wren_d   = ram_wren;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0;
    rdata1_d = rdata1;
    busy_d   = busy;
    unique case (state_q)
      INIT: begin
        // wren low marks the first clear edge; the address
        // register doubles as the clear counter.
        if (!ram_wren) begin
          addr_d = '0;
          data_d = CLR;
          wren_d = 1'b1;
        end else if (ram_address == LAST) begin
          wren_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          addr_d = ram_address + ADDR_W'(1);
        end
      end
      IDLE: begin
        wren_d = 1'b0;
        if (gnt_valid) begin
          grant_d = gnt_idx;
          if (gnt_idx == P1) begin
            addr_d  = addr1;
            data_d  = wdata1;
            wren_d  = we1;
            op_we_d = we1;
          end else begin
            addr_d  = addr0;
            data_d  = wdata0;
            wren_d  = we0;
            op_we_d = we0;
          end
          if (&elig) ptr_d = ~gnt_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wren_d  = 1'b0;
        state_d = DATA;
      end
      DATA: begin
        if (grant == P1) begin
          ack1_d = 1'b1;
          if (!op_we_q) rdata1_d = ram_q;
        end else begin
          ack0_d = 1'b1;
          if (!op_we_q) rdata0_d = ram_q;
        end
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

endmodule
